reg_status_file: RTL and testbench

//   Architectural register file with per-register rename status (busy bit + ROB tag).

---
 rtl/reg_status_file_pkg.sv | 21 ++
 rtl/reg_status_file_read_port.sv | 37 +++
 rtl/reg_status_file.sv | 103 ++++++++++
 tb/tb_reg_status_file.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_status_file_pkg.sv
// Shared sizing constants and the read-view record for the register/status file.
// Optional same-cycle commit bypass on the read ports is enabled by REGFILE_BYPASS_EN.
package reg_status_file_pkg;

  localparam int REG_NUM         = 32;
  localparam int REG_WIDTH       = 5;
  localparam int DATA_WIDTH      = 32;
  localparam int ROB_ENTRY_WIDTH = 3;

  typedef logic [REG_WIDTH-1:0]       reg_idx_t;
  typedef logic [DATA_WIDTH-1:0]      reg_data_t;
  typedef logic [ROB_ENTRY_WIDTH-1:0] rob_tag_t;

  // What one read port presents: value, pending-writer flag and owning ROB entry.
  typedef struct packed {
    reg_data_t data;
    logic      busy;
    rob_tag_t  tag;
  } rd_view_t;

endpackage

// File: rtl/reg_status_file_read_port.sv
// One source-operand read port: masks the tag of idle registers, forces r0 to zero and,
// when REGFILE_BYPASS_EN is defined, forwards a same-cycle ROB commit to the reader.
module reg_read_port
  import reg_status_file_pkg::*;
(
  input  reg_idx_t  rd_reg_i,
  input  rd_view_t  stored_i,
`ifdef REGFILE_BYPASS_EN
  input  logic      commit_en_i,
  input  reg_idx_t  commit_name_i,
  input  reg_data_t commit_data_i,
  input  rob_tag_t  commit_entry_i,
`endif
  output rd_view_t  view_o
);

  always_comb begin
    view_o = stored_i;
    if (!stored_i.busy) begin
      view_o.tag = '0;
    end
`ifdef REGFILE_BYPASS_EN
    // A stale commit forwards only its data; the newer owner keeps the lock.
    if (commit_en_i && (commit_name_i == rd_reg_i)) begin
      view_o.data = commit_data_i;
      if (stored_i.busy && (stored_i.tag == commit_entry_i)) begin
        view_o.busy = 1'b0;
        view_o.tag  = '0;
      end
    end
`endif
    if (rd_reg_i == '0) begin
      view_o = '0;
    end
  end

endmodule

// File: rtl/reg_status_file.sv
// Architectural register file with per-register busy bit and ROB tag (rename status).
// Build option REGFILE_BYPASS_EN forwards same-cycle commits to both read ports.
module reg_status_file
  import reg_status_file_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  reg_idx_t  rd_reg1,
  output reg_data_t rd_data1,
  output logic      rd_busy1,
  output rob_tag_t  rd_tag1,
  input  reg_idx_t  rd_reg2,
  output reg_data_t rd_data2,
  output logic      rd_busy2,
  output rob_tag_t  rd_tag2,
  input  logic      lock_en,
  input  reg_idx_t  lock_reg,
  input  rob_tag_t  lock_entry,
  input  logic      reg_modify,
  input  reg_idx_t  reg_name,
  input  reg_data_t reg_data,
  input  rob_tag_t  reg_entry,
  input  logic      flush
);

  // No handshake: lock, commit and flush requests are accepted unconditionally every cycle.
  logic [REG_NUM-1:0][DATA_WIDTH-1:0]      data_q, data_d;
  logic [REG_NUM-1:0]                      busy_q, busy_d;
  logic [REG_NUM-1:0][ROB_ENTRY_WIDTH-1:0] tag_q,  tag_d;

  logic commit_valid, lock_valid;
  assign commit_valid = reg_modify && (reg_name != '0);
  assign lock_valid   = lock_en && (lock_reg != '0) && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q <= '0;
      busy_q <= '0;
      tag_q  <= '0;
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  // Commit is applied before lock so a same-cycle lock on the same register wins the status.
  always_comb begin
    data_d = data_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (commit_valid) begin
      data_d[reg_name] = reg_data;
      if (busy_q[reg_name] && (tag_q[reg_name] == reg_entry)) begin
        busy_d[reg_name] = 1'b0;
        tag_d[reg_name]  = '0;
      end
    end
    if (flush) begin
      busy_d = '0;
      tag_d  = '0;
    end else if (lock_valid) begin
      busy_d[lock_reg] = 1'b1;
      tag_d[lock_reg]  = lock_entry;
    end
  end

  rd_view_t stored1, stored2, view1, view2;
  assign stored1 = '{data: data_q[rd_reg1], busy: busy_q[rd_reg1], tag: tag_q[rd_reg1]};
  assign stored2 = '{data: data_q[rd_reg2], busy: busy_q[rd_reg2], tag: tag_q[rd_reg2]};

  reg_read_port u_port1 (
    .rd_reg_i       (rd_reg1),
    .stored_i       (stored1),
`ifdef REGFILE_BYPASS_EN
    .commit_en_i    (commit_valid),
    .commit_name_i  (reg_name),
    .commit_data_i  (reg_data),
    .commit_entry_i (reg_entry),
`endif
    .view_o         (view1)
  );

  reg_read_port u_port2 (
    .rd_reg_i       (rd_reg2),
    .stored_i       (stored2),
`ifdef REGFILE_BYPASS_EN
    .commit_en_i    (commit_valid),
    .commit_name_i  (reg_name),
    .commit_data_i  (reg_data),
    .commit_entry_i (reg_entry),
`endif
    .view_o         (view2)
  );

  assign rd_data1 = view1.data;
  assign rd_busy1 = view1.busy;
  assign rd_tag1  = view1.tag;
  assign rd_data2 = view2.data;
  assign rd_busy2 = view2.busy;
  assign rd_tag2  = view2.tag;

endmodule

// File: tb/tb_reg_status_file.sv
// Self-checking bench for reg_status_file: directed scenarios then randomized traffic,
// compared against an array-based model of the architectural/rename state.
module tb_reg_status_file;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rd_reg1 = '0, rd_reg2 = '0;
  logic [31:0] rd_data1, rd_data2;
  logic        rd_busy1, rd_busy2;
  logic [2:0]  rd_tag1, rd_tag2;
  logic        lock_en = 1'b0;
  logic [4:0]  lock_reg = '0;
  logic [2:0]  lock_entry = '0;
  logic        reg_modify = 1'b0;
  logic [4:0]  reg_name = '0;
  logic [31:0] reg_data = '0;
  logic [2:0]  reg_entry = '0;
  logic        flush = 1'b0;

  int checks = 0;
  int failures = 0;

  // Reference model: architectural value, pending flag and owner per register.
  logic [31:0] m_data [32];
  bit          m_busy [32];
  logic [2:0]  m_tag  [32];

  reg_status_file dut (
    .clk(clk), .rst(rst),
    .rd_reg1(rd_reg1), .rd_data1(rd_data1), .rd_busy1(rd_busy1), .rd_tag1(rd_tag1),
    .rd_reg2(rd_reg2), .rd_data2(rd_data2), .rd_busy2(rd_busy2), .rd_tag2(rd_tag2),
    .lock_en(lock_en), .lock_reg(lock_reg), .lock_entry(lock_entry),
    .reg_modify(reg_modify), .reg_name(reg_name), .reg_data(reg_data),
    .reg_entry(reg_entry), .flush(flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_data[i] = '0;
      m_busy[i] = 0;
      m_tag[i]  = '0;
    end
  endtask

  // Expected read result for register r given the inputs currently driven.
  task automatic expect_read(input int r, output logic [31:0] d, output logic b, output logic [2:0] t);
    d = m_data[r];
    b = m_busy[r];
    t = m_busy[r] ? m_tag[r] : 3'd0;
`ifdef REGFILE_BYPASS_EN
    if (reg_modify && reg_name == r && r != 0) begin
      d = reg_data;
      if (m_busy[r] && m_tag[r] == reg_entry) begin
        b = 0;
        t = 3'd0;
      end
    end
`endif
    if (r == 0) begin
      d = '0;
      b = 0;
      t = 3'd0;
    end
  endtask

  task automatic check_ports(input string tag);
    logic [31:0] d;
    logic        b;
    logic [2:0]  t;
    expect_read(int'(rd_reg1), d, b, t);
    check({tag, ".p1.data"}, rd_data1, d);
    check({tag, ".p1.busy"}, 32'(rd_busy1), 32'(b));
    check({tag, ".p1.tag"},  32'(rd_tag1),  32'(t));
    expect_read(int'(rd_reg2), d, b, t);
    check({tag, ".p2.data"}, rd_data2, d);
    check({tag, ".p2.busy"}, 32'(rd_busy2), 32'(b));
    check({tag, ".p2.tag"},  32'(rd_tag2),  32'(t));
  endtask

  // Apply the clock edge to the model from the specification's rules.
  task automatic model_edge();
    int c, l;
    c = int'(reg_name);
    l = int'(lock_reg);
    if (reg_modify && c != 0) begin
      m_data[c] = reg_data;
      if (m_busy[c] && m_tag[c] == reg_entry) m_busy[c] = 0;
    end
    if (flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 0;
    end else if (lock_en && l != 0) begin
      m_busy[l] = 1;
      m_tag[l]  = lock_entry;
    end
  endtask

  // One cycle, starting and ending on a falling edge.
  task automatic cycle(input string tag, input bit le, input int lr, input int lent,
                       input bit cm, input int cn, input logic [31:0] cd, input int cent,
                       input bit fl, input int r1, input int r2);
    lock_en = le; lock_reg = 5'(lr); lock_entry = 3'(lent);
    reg_modify = cm; reg_name = 5'(cn); reg_data = cd; reg_entry = 3'(cent);
    flush = fl; rd_reg1 = 5'(r1); rd_reg2 = 5'(r2);
    #1;
    check_ports(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle_read(input string tag, input int r1, input int r2);
    cycle(tag, 0, 0, 0, 0, 0, 32'h0, 0, 0, r1, r2);
  endtask

  initial begin
    model_reset();
    #2;
    check_ports("reset");
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-run, asserted between edges.
    cycle("rst_lock", 1, 5, 3, 0, 0, 32'h0, 0, 0, 5, 0);
    idle_read("rst_pre", 5, 5);
    check("rst_pre.busy5", 32'(rd_busy1), 32'd1);
    #2 rst = 1'b1;
    model_reset();
    for (int i = 0; i < 32; i++) begin
      rd_reg1 = 5'(i);
      rd_reg2 = 5'(31 - i);
      #1;
      check("rst_async.data", rd_data1, 32'h0);
      check("rst_async.busy", 32'(rd_busy1), 32'd0);
      check("rst_async.tag",  32'(rd_tag2),  32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    // Lock then matching commit.
    cycle("lc_lock", 1, 5, 3, 0, 0, 32'h0, 0, 0, 5, 5);
    cycle("lc_commit", 0, 0, 0, 1, 5, 32'hDEADBEEF, 3, 0, 5, 0);
    idle_read("lc_after", 5, 0);
    check("lc.data5", rd_data1, 32'hDEADBEEF);
    check("lc.busy5", 32'(rd_busy1), 32'd0);

    // Stale commit keeps the newer lock.
    cycle("st_l1", 1, 7, 1, 0, 0, 32'h0, 0, 0, 7, 0);
    cycle("st_l4", 1, 7, 4, 0, 0, 32'h0, 0, 0, 7, 0);
    cycle("st_cm", 0, 0, 0, 1, 7, 32'h11, 1, 0, 7, 0);
    idle_read("st_after", 7, 0);
    check("st.data7", rd_data1, 32'h11);
    check("st.busy7", 32'(rd_busy1), 32'd1);
    check("st.tag7",  32'(rd_tag1),  32'd4);

    // Same-cycle lock and commit on r9.
    cycle("sc_l2", 1, 9, 2, 0, 0, 32'h0, 0, 0, 9, 0);
    cycle("sc_both", 1, 9, 6, 1, 9, 32'h22, 2, 0, 9, 9);
    idle_read("sc_after", 9, 0);
    check("sc.data9", rd_data1, 32'h22);
    check("sc.busy9", 32'(rd_busy1), 32'd1);
    check("sc.tag9",  32'(rd_tag1),  32'd6);

    // Flush with a concurrent commit and a dropped lock.
    cycle("fl_l1", 1, 1, 1, 0, 0, 32'h0, 0, 0, 1, 0);
    cycle("fl_l2", 1, 2, 2, 0, 0, 32'h0, 0, 0, 2, 1);
    cycle("fl_l3", 1, 3, 3, 0, 0, 32'h0, 0, 0, 3, 2);
    cycle("fl_go", 1, 8, 5, 1, 4, 32'h33, 0, 1, 4, 8);
    idle_read("fl_r4r8", 4, 8);
    check("fl.data4", rd_data1, 32'h33);
    check("fl.busy8", 32'(rd_busy2), 32'd0);
    for (int i = 1; i < 32; i++) begin
      rd_reg1 = 5'(i);
      #1;
      check("fl.all_idle", 32'(rd_busy1), 32'd0);
    end
    @(negedge clk);

    // Register 0 is hardwired.
    cycle("r0_lock", 1, 0, 2, 0, 0, 32'h0, 0, 0, 0, 0);
    cycle("r0_cm", 0, 0, 0, 1, 0, 32'hFF, 2, 0, 0, 0);
    idle_read("r0_after", 0, 0);
    check("r0.data", rd_data1, 32'h0);
    check("r0.busy", 32'(rd_busy2), 32'd0);

    // Randomized traffic on a small register window to force collisions.
    for (int n = 0; n < 400; n++) begin
      cycle("rand",
            1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 32'($urandom()),
            int'($urandom_range(0, 7)), ($urandom_range(0, 19) == 0),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 31)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
